// File: rtl/sram_boot_cfg_loader.sv
// sram_boot_cfg_loader
//
// Boot-time configuration fetcher. While loading, it holds the machine core in
// reset and owns the SRAM address/WE lines. It reads NUM_BYTES consecutive
// bytes starting at CFG_BASE, then releases the core and hands the SRAM bus
// back. In RUN, a reload pulse restarts the fetch.
//
// Optional feature (macro BOOT_CFG_CHECKSUM_EN): one extra checksum byte is
// read at CFG_BASE+NUM_BYTES. On a mismatch the image is replaced by
// DEFAULT_CFG and cfg_error is raised.
//
// Ports:
//   clk_sys       in   system clock
//   reset_n       in   synchronous active-low reset
//   reload        in   single-cycle re-load request (honoured only in RUN)
//   core_addr     in   core's SRAM address
//   core_we_n     in   core's SRAM write enable, active-low
//   sram_data_in  in   data read from SRAM
//   sram_addr     out  address to SRAM pins
//   sram_we_n     out  write enable to SRAM pins, active-low
//   core_reset_n  out  reset to the machine core, active-low
//   cfg_bytes     out  captured config; byte i at [8i+7:8i]
//   cfg_valid     out  high while cfg_bytes holds a completed load
//   cfg_error     out  checksum failure flag (0 when the feature is off)

module sram_boot_cfg_loader #(
  parameter int unsigned       ADDR_W        = 19,
  parameter logic [ADDR_W-1:0] CFG_BASE      = 19'h08FD5,
  parameter int unsigned       NUM_BYTES     = 1,
  parameter int unsigned       SETTLE_CYCLES = 2,
  parameter logic [63:0]       DEFAULT_CFG   = 64'h0
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   reload,
  input  logic [ADDR_W-1:0]      core_addr,
  input  logic                   core_we_n,
  input  logic [7:0]             sram_data_in,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic                   sram_we_n,
  output logic                   core_reset_n,
  output logic [8*NUM_BYTES-1:0] cfg_bytes,
  output logic                   cfg_valid,
  output logic                   cfg_error
);

  // Index of the last byte fetched; the checksum byte sits just past the image.
`ifdef BOOT_CFG_CHECKSUM_EN
  localparam logic [3:0] LastIdx = 4'(NUM_BYTES);
`else
  localparam logic [3:0] LastIdx = 4'(NUM_BYTES - 1);
`endif
  localparam logic [3:0] CntMax = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StLoad, StDone, StRun} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [8*NUM_BYTES-1:0] cfg_q, cfg_d;
  logic                   valid_q, valid_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   err_q, err_d;

`ifdef BOOT_CFG_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic [7:0] xor_sum;
`else
  logic unused_default_cfg;
  assign unused_default_cfg = ^DEFAULT_CFG;
`endif

  // SRAM bus ownership: the loader drives it outside RUN, the core inside RUN.
  always_comb begin
    sram_addr = CFG_BASE + ADDR_W'(idx_q);
    sram_we_n = 1'b1;
    if (state_q == StRun) begin
      sram_addr = core_addr;
      sram_we_n = core_we_n;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    cfg_d        = cfg_q;
    valid_d      = valid_q;
    core_rst_n_d = core_rst_n_q;
    err_d        = err_q;
`ifdef BOOT_CFG_CHECKSUM_EN
    chk_d   = chk_q;
    xor_sum = 8'hA5;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      xor_sum = xor_sum ^ cfg_q[8*i +: 8];
    end
`endif

    unique case (state_q)
      StLoad: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == 4'(i)) cfg_d[8*i +: 8] = sram_data_in;
          end
`ifdef BOOT_CFG_CHECKSUM_EN
          if (idx_q == 4'(NUM_BYTES)) chk_d = sram_data_in;
`endif
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        valid_d      = 1'b1;
        core_rst_n_d = 1'b1;
        state_d      = StRun;
`ifdef BOOT_CFG_CHECKSUM_EN
        if (xor_sum != chk_q) begin
          cfg_d = DEFAULT_CFG[8*NUM_BYTES-1:0];
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
`endif
      end
      StRun: begin
        if (reload) begin
          core_rst_n_d = 1'b0;
          valid_d      = 1'b0;
          idx_d        = '0;
          cnt_d        = '0;
          err_d        = 1'b0;
          state_d      = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= StLoad;
      idx_q        <= '0;
      cnt_q        <= '0;
      cfg_q        <= '0;
      valid_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef BOOT_CFG_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      cfg_q        <= cfg_d;
      valid_q      <= valid_d;
      core_rst_n_q <= core_rst_n_d;
      err_q        <= err_d;
`ifdef BOOT_CFG_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign cfg_bytes    = cfg_q;
  assign cfg_valid    = valid_q;
  assign core_reset_n = core_rst_n_q;
`ifdef BOOT_CFG_CHECKSUM_EN
  assign cfg_error    = err_q;
`else
  assign cfg_error    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_boot_cfg_loader.sv
// Testbench for sram_boot_cfg_loader: two instances (1-byte image at the
// default base, 4-byte image wrapping the top of the address space) share the
// clock, reset and core bus. Each SRAM is a small byte array relative to its
// base. The reference model tracks, per instance, the number of edges since
// the current load began and derives all expected outputs from that count.

module tb_sram_boot_cfg_loader;

  localparam int          S     = 2;
  localparam int          NBA   = 1;
  localparam int          NBB   = 4;
  localparam logic [18:0] BASEA = 19'h08FD5;
  localparam logic [18:0] BASEB = 19'h7FFFE;
  localparam logic [63:0] DEF   = 64'hCAFE_F00D_1234_5678;
`ifdef BOOT_CFG_CHECKSUM_EN
  localparam int X = 1;
`else
  localparam int X = 0;
`endif
  localparam int LA = (NBA + X) * (S + 1) + 1;
  localparam int LB = (NBB + X) * (S + 1) + 1;

  logic        clk;
  logic        reset_n;
  logic        reload_a, reload_b;
  logic [18:0] core_addr;
  logic        core_we_n;
  logic [7:0]  data_a, data_b;
  logic [18:0] addr_a, addr_b, off_a, off_b;
  logic        we_a, we_b, crst_a, crst_b, valid_a, valid_b, err_a, err_b;
  logic [7:0]  cfg_a;
  logic [31:0] cfg_b;

  logic [127:0] mem_a, mem_b, img_a, img_b;
  logic [63:0]  old_a, old_b;
  int           ka, kb;
  int           n_checks, n_fail;

  sram_boot_cfg_loader #(
    .ADDR_W(19), .CFG_BASE(BASEA), .NUM_BYTES(NBA), .SETTLE_CYCLES(S), .DEFAULT_CFG(DEF)
  ) u_dut_a (
    .clk_sys(clk), .reset_n(reset_n), .reload(reload_a), .core_addr(core_addr),
    .core_we_n(core_we_n), .sram_data_in(data_a), .sram_addr(addr_a), .sram_we_n(we_a),
    .core_reset_n(crst_a), .cfg_bytes(cfg_a), .cfg_valid(valid_a), .cfg_error(err_a)
  );

  sram_boot_cfg_loader #(
    .ADDR_W(19), .CFG_BASE(BASEB), .NUM_BYTES(NBB), .SETTLE_CYCLES(S), .DEFAULT_CFG(DEF)
  ) u_dut_b (
    .clk_sys(clk), .reset_n(reset_n), .reload(reload_b), .core_addr(core_addr),
    .core_we_n(core_we_n), .sram_data_in(data_b), .sram_addr(addr_b), .sram_we_n(we_b),
    .core_reset_n(crst_b), .cfg_bytes(cfg_b), .cfg_valid(valid_b), .cfg_error(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: 16 bytes from each base, 8'hEE elsewhere.
  always_comb begin
    off_a  = addr_a - BASEA;
    off_b  = addr_b - BASEB;
    data_a = (off_a < 19'd16) ? mem_a[int'(off_a[3:0]) * 8 +: 8] : 8'hEE;
    data_b = (off_b < 19'd16) ? mem_b[int'(off_b[3:0]) * 8 +: 8] : 8'hEE;
  end

  function automatic int load_len(int nb);
    return (nb + X) * (S + 1) + 1;
  endfunction

  function automatic logic [127:0] with_sum(logic [127:0] m, int nb, bit good);
    logic [7:0] x;
    x = 8'hA5;
    for (int i = 0; i < nb; i++) x = x ^ m[8*i +: 8];
    m[8*nb +: 8] = good ? x : ~x;
    return m;
  endfunction

  function automatic bit bad_sum(logic [127:0] img, int nb);
    logic [7:0] x;
    x = 8'hA5;
    for (int i = 0; i < nb; i++) x = x ^ img[8*i +: 8];
    return x != img[8*nb +: 8];
  endfunction

  // Byte i is replaced once (i+1)*(S+1) edges of the load have elapsed.
  function automatic logic [63:0] exp_cfg(logic [63:0] old, logic [127:0] img, int nb, int k);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < nb; i++) begin
      if (k >= (i + 1) * (S + 1)) r[8*i +: 8] = img[8*i +: 8];
    end
    if (X == 1 && k >= load_len(nb) && bad_sum(img, nb)) r = DEF;
    for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [18:0] exp_addr(logic [18:0] base, int nb, int k);
    int slot;
    slot = k / (S + 1);
    if (slot > nb + X - 1) slot = nb + X - 1;
    return base + 19'(slot);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(string tag, int k, int nb, logic [18:0] base, logic [63:0] old,
                           logic [127:0] img, logic [18:0] a, logic we, logic crst, logic v,
                           logic [63:0] cfg, logic err);
    bit loading;
    string t;
    loading = k < load_len(nb);
    t = $sformatf("%s k=%0d", tag, k);
    chk({t, " sram_addr"}, 64'(a), 64'(loading ? exp_addr(base, nb, k) : core_addr));
    chk({t, " sram_we_n"}, 64'(we), 64'(loading ? 1'b1 : core_we_n));
    chk({t, " core_reset_n"}, 64'(crst), 64'(!loading));
    chk({t, " cfg_valid"}, 64'(v), 64'(!loading));
    chk({t, " cfg_bytes"}, cfg, exp_cfg(old, img, nb, k));
    chk({t, " cfg_error"}, 64'(err), 64'(X == 1 && !loading && bad_sum(img, nb)));
  endtask

  task automatic check_all();
    check_dut("A", ka, NBA, BASEA, old_a, img_a, addr_a, we_a, crst_a, valid_a,
              {56'h0, cfg_a}, err_a);
    check_dut("B", kb, NBB, BASEB, old_b, img_b, addr_b, we_b, crst_b, valid_b,
              {32'h0, cfg_b}, err_b);
  endtask

  // One clock edge: advance the model with the inputs seen at that edge, then check.
  task automatic tick();
    logic r, la, lb;
    r  = reset_n;
    la = reload_a;
    lb = reload_b;
    @(posedge clk);
    #1;
    if (!r) begin
      ka = 0; kb = 0; old_a = '0; old_b = '0; img_a = mem_a; img_b = mem_b;
    end else begin
      if (la && ka >= LA) begin
        old_a = exp_cfg(old_a, img_a, NBA, ka); img_a = mem_a; ka = 0;
      end else begin
        ka++;
      end
      if (lb && kb >= LB) begin
        old_b = exp_cfg(old_b, img_b, NBB, kb); img_b = mem_b; kb = 0;
      end else begin
        kb++;
      end
    end
    check_all();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    reload_a  = 1'b0;
    reload_b  = 1'b0;
    core_addr = 19'($urandom);
    core_we_n = 1'($urandom);
    mem_a     = with_sum({$urandom, $urandom, $urandom, $urandom}, NBA, 1'b1);
    mem_b     = with_sum({$urandom, $urandom, $urandom, $urandom}, NBB, 1'b0);
    ka = 0; kb = 0; old_a = '0; old_b = '0; img_a = mem_a; img_b = mem_b;

    // Reset state, then the initial load with random core activity on the bus.
    tick();
    tick();
    reset_n = 1'b1;
    repeat (LB + 3) begin
      core_addr = 19'($urandom);
      core_we_n = 1'($urandom);
      tick();
    end

    // Same-cycle pass-through in RUN.
    core_addr = 19'h12345;
    core_we_n = 1'b0;
    #1;
    check_all();

    // Reload of A with a new byte 0; a second pulse during its load is ignored.
    mem_a[7:0] = 8'hFE;
    mem_a      = with_sum(mem_a, NBA, 1'($urandom_range(0, 1)));
    reload_a   = 1'b1;
    tick();
    reload_a   = 1'b0;
    tick();
    reload_a   = 1'b1;
    tick();
    reload_a   = 1'b0;
    repeat (LA + 2) tick();

    // Reload of B, aborted by a one-edge reset mid-load; both restart from byte 0.
    mem_b    = with_sum({$urandom, $urandom, $urandom, $urandom}, NBB, 1'b1);
    reload_b = 1'b1;
    tick();
    reload_b = 1'b0;
    repeat (5) tick();
    reset_n  = 1'b0;
    reload_a = 1'b1;
    reload_b = 1'b1;
    tick();
    reset_n  = 1'b1;
    reload_a = 1'b0;
    reload_b = 1'b0;
    repeat (LB + 2) tick();

    // Randomized rounds: new SRAM contents, random reload pulses and core traffic.
    for (int r = 0; r < 4; r++) begin
      mem_a = with_sum({$urandom, $urandom, $urandom, $urandom}, NBA, 1'($urandom_range(0, 1)));
      mem_b = with_sum({$urandom, $urandom, $urandom, $urandom}, NBB, 1'($urandom_range(0, 1)));
      repeat (30) begin
        core_addr = 19'($urandom);
        core_we_n = 1'($urandom);
        reload_a  = ($urandom_range(0, 5) == 0);
        reload_b  = ($urandom_range(0, 5) == 0);
        tick();
      end
      reload_a = 1'b0;
      reload_b = 1'b0;
      repeat (LB + 2) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
